// File: rtl/byte_ram_arbiter.sv
// byte_ram_arbiter: zero-fills a byte-write simple-dual-port RAM after reset, then shares its
// write and read ports between NUM_REQ requesters with round-robin arbitration, one request
// per cycle, and routes 1-cycle-registered read data back to the requester that issued it.
module byte_ram_arbiter #(
    parameter int unsigned ADDR_DEPTH = 32,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_strb,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             init_done,
    output logic                             ram_wr_enable,
    output logic [ADDR_WIDTH-1:0]            ram_wr_address,
    output logic [DATA_WIDTH-1:0]            ram_wr_data,
    output logic [DATA_WIDTH/8-1:0]          ram_wr_strb,
    output logic [ADDR_WIDTH-1:0]            ram_rd_address,
    input  logic [DATA_WIDTH-1:0]            ram_rd_data
);

    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
    localparam int unsigned IDX_W      = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;
    localparam int unsigned PTR_W      = $clog2(NUM_REQ);

    typedef enum logic {StInit, StRun} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    init_done_q, init_done_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [STRB_W-1:0]       wr_strb_q, wr_strb_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    // tag1 tracks the RAM address stage, tag2 the RAM data stage
    logic [NUM_REQ-1:0]      tag1_q, tag1_d;
    logic [NUM_REQ-1:0]      tag2_q, tag2_d;

    logic [NUM_REQ-1:0]      grant;
    logic [PTR_W-1:0]        gnt_idx;
    logic                    found;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_W-1:0]       sel_strb;

    // Round-robin grant: first pass looks above the last-granted index, second pass wraps.
    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        if (state_q == StRun) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && (PTR_W'(i) > ptr_q)) begin
                    found     = 1'b1;
                    gnt_idx   = PTR_W'(i);
                    grant[i]  = 1'b1;
                    sel_write = req_write[i];
                    sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    sel_strb  = req_strb[i*STRB_W +: STRB_W];
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && (PTR_W'(i) <= ptr_q)) begin
                    found     = 1'b1;
                    gnt_idx   = PTR_W'(i);
                    grant[i]  = 1'b1;
                    sel_write = req_write[i];
                    sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    sel_strb  = req_strb[i*STRB_W +: STRB_W];
                end
            end
        end
    end

    // Next state: zero-fill sweep in StInit, issue the granted request in StRun.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
        rd_addr_d   = rd_addr_q;
        tag1_d      = '0;
        tag2_d      = tag1_q;
        case (state_q)
            StInit: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_WIDTH'(idx_q) << BYTE_SHIFT;
                wr_data_d = '0;
                wr_strb_d = '1;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(ADDR_DEPTH - 1)) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                    idx_d       = '0;
                end
            end
            StRun: begin
                if (found) begin
                    ptr_d = gnt_idx;
                    if (sel_write) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_wdata;
                        wr_strb_d = sel_strb;
                    end else begin
                        rd_addr_d = sel_addr;
                        tag1_d    = grant;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    // State and output registers; reset drops any in-flight read tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            idx_q       <= '0;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            init_done_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            rd_addr_q   <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            rd_addr_q   <= rd_addr_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
        end
    end

    assign req_ready      = grant;
    assign rsp_valid      = tag2_q;
    assign rsp_rdata      = ram_rd_data;
    assign init_done      = init_done_q;
    assign ram_wr_enable  = wr_en_q;
    assign ram_wr_address = wr_addr_q;
    assign ram_wr_data    = wr_data_q;
    assign ram_wr_strb    = wr_strb_q;
    assign ram_rd_address = rd_addr_q;

endmodule

// File: tb/tb_byte_ram_arbiter.sv
// Bench for byte_ram_arbiter: behavioural byte-write RAM, init sweep check, a table of
// per-cycle vectors for the run phase, and a mid-flight reset sequence.
module tb_byte_ram_arbiter;

    localparam int AD = 32;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NR = 2;
    localparam int SW = DW / 8;
    localparam int NV = 21;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SW-1:0]  req_strb;
    logic [DW-1:0]     rsp_rdata, ram_wr_data, ram_rd_data;
    logic              init_done, ram_wr_enable;
    logic [AW-1:0]     ram_wr_address, ram_rd_address;
    logic [SW-1:0]     ram_wr_strb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    byte_ram_arbiter #(
        .ADDR_DEPTH(AD), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .ram_wr_enable(ram_wr_enable), .ram_wr_address(ram_wr_address),
        .ram_wr_data(ram_wr_data), .ram_wr_strb(ram_wr_strb),
        .ram_rd_address(ram_rd_address), .ram_rd_data(ram_rd_data)
    );

    // Behavioural RAM: byte-strobed write, registered read, word index from byte address
    logic [DW-1:0] mem [0:AD-1];
    always @(posedge clk) begin
        if (ram_wr_enable) begin
            for (int b = 0; b < SW; b++)
                if (ram_wr_strb[b]) mem[ram_wr_address[5:1]][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
        end
        ram_rd_data <= mem[ram_rd_address[5:1]];
    end

    // Requester protocol: valid without ready must persist with a stable payload
    logic [NR-1:0] pend;
    logic [NR*AW-1:0] p_addr;
    logic [NR*DW-1:0] p_wdata;
    logic [NR*SW-1:0] p_strb;
    logic [NR-1:0] p_write;
    always @(posedge clk) begin
        if (!rst_n || !init_done) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (pend[i]) begin
                    checks++;
                    if (!req_valid[i] || req_write[i] !== p_write[i]
                        || req_addr[i*AW +: AW] !== p_addr[i*AW +: AW]
                        || req_wdata[i*DW +: DW] !== p_wdata[i*DW +: DW]
                        || req_strb[i*SW +: SW] !== p_strb[i*SW +: SW]) begin
                        errors++;
                        $display("FAIL hold_stable req%0d: valid %b payload changed", i,
                                 req_valid[i]);
                    end
                end
            end
            pend    <= req_valid & ~req_ready;
            p_addr  <= req_addr;
            p_wdata <= req_wdata;
            p_strb  <= req_strb;
            p_write <= req_write;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [31:0] addr0, addr1;
        logic [15:0] wdata0, wdata1;
        logic [1:0]  strb0, strb1;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rsp;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(logic [1:0] v, logic [1:0] w, logic [31:0] a0, logic [31:0] a1,
                                logic [15:0] d0, logic [15:0] d1, logic [1:0] s0,
                                logic [1:0] s1, logic [1:0] er, logic [1:0] ev,
                                logic [15:0] ed);
        vec_t r;
        r.valid = v; r.write = w; r.addr0 = a0; r.addr1 = a1;
        r.wdata0 = d0; r.wdata1 = d1; r.strb0 = s0; r.strb1 = s1;
        r.exp_ready = er; r.exp_rsp = ev; r.exp_rdata = ed;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        req_valid = r.valid;
        req_write = r.write;
        req_addr  = {r.addr1, r.addr0};
        req_wdata = {r.wdata1, r.wdata0};
        req_strb  = {r.strb1, r.strb0};
    endtask

    initial begin
        // Row k is presented for one cycle; reads return two rows later
        vecs[0]  = mk(2'b01, 2'b01, 4, 0, 16'hA5C3, 0, 2'b11, 0, 2'b01, 2'b00, 0);
        vecs[1]  = mk(2'b01, 2'b00, 4, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        vecs[2]  = mk(2'b01, 2'b01, 4, 0, 16'h1234, 0, 2'b01, 0, 2'b01, 2'b00, 0);
        vecs[3]  = mk(2'b01, 2'b00, 4, 0, 0, 0, 0, 0, 2'b01, 2'b01, 16'hA5C3);
        vecs[4]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        vecs[5]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 16'hA534);
        vecs[6]  = mk(2'b10, 2'b10, 0, 0, 0, 16'hBEEF, 0, 2'b11, 2'b10, 2'b00, 0);
        vecs[7]  = mk(2'b10, 2'b10, 0, 2, 0, 16'hCAFE, 0, 2'b11, 2'b10, 2'b00, 0);
        vecs[8]  = mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        vecs[9]  = mk(2'b10, 2'b00, 0, 2, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        vecs[10] = mk(2'b10, 2'b00, 0, 4, 0, 0, 0, 0, 2'b10, 2'b10, 16'hBEEF);
        vecs[11] = mk(2'b11, 2'b00, 0, 2, 0, 0, 0, 0, 2'b01, 2'b10, 16'hCAFE);
        vecs[12] = mk(2'b11, 2'b00, 0, 2, 0, 0, 0, 0, 2'b10, 2'b10, 16'hA534);
        vecs[13] = mk(2'b11, 2'b00, 0, 2, 0, 0, 0, 0, 2'b01, 2'b01, 16'hBEEF);
        vecs[14] = mk(2'b11, 2'b00, 0, 2, 0, 0, 0, 0, 2'b10, 2'b10, 16'hCAFE);
        vecs[15] = mk(2'b11, 2'b00, 0, 2, 0, 0, 0, 0, 2'b01, 2'b01, 16'hBEEF);
        vecs[16] = mk(2'b11, 2'b00, 0, 2, 0, 0, 0, 0, 2'b10, 2'b10, 16'hCAFE);
        vecs[17] = mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 16'hBEEF);
        vecs[18] = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 16'hCAFE);
        vecs[19] = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 16'hBEEF);
        vecs[20] = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Reset with requests already pending; they must be ignored during the sweep
        rst_n = 1'b1;
        drive(mk(2'b11, 2'b10, 8, 6, 0, 16'hFFFF, 0, 2'b11, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_init_done", 32'(init_done), 0);
        chk("reset_wr_enable", 32'(ram_wr_enable), 0);
        chk("reset_wr_address", ram_wr_address, 0);
        chk("reset_wr_strb", 32'(ram_wr_strb), 0);
        chk("reset_rd_address", ram_rd_address, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int c = 0; c < AD; c++) begin
            @(posedge clk); #1;
            chk($sformatf("init_wr_en[%0d]", c), 32'(ram_wr_enable), 1);
            chk($sformatf("init_wr_addr[%0d]", c), ram_wr_address, 32'(2 * c));
            chk($sformatf("init_wr_data[%0d]", c), 32'(ram_wr_data), 0);
            chk($sformatf("init_wr_strb[%0d]", c), 32'(ram_wr_strb), 3);
            chk($sformatf("init_done[%0d]", c), 32'(init_done), (c == AD - 1) ? 1 : 0);
            if (c < AD - 1) chk($sformatf("init_ready[%0d]", c), 32'(req_ready), 0);
        end

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k]);
            #1;
            chk($sformatf("ready[%0d]", k), 32'(req_ready), 32'(vecs[k].exp_ready));
            chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid), 32'(vecs[k].exp_rsp));
            if (vecs[k].exp_rsp != 2'b00)
                chk($sformatf("rsp_rdata[%0d]", k), 32'(rsp_rdata), 32'(vecs[k].exp_rdata));
            @(posedge clk); #1;
        end

        // Reset while a read is in flight
        drive(mk(2'b01, 2'b00, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("inflight_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        drive(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        chk("midrst_wr_enable", 32'(ram_wr_enable), 0);
        chk("midrst_rd_address", ram_rd_address, 0);
        @(posedge clk); #1;
        chk("midrst_rsp_valid_hold", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        for (int c = 0; c < AD; c++) begin
            @(posedge clk); #1;
            chk($sformatf("reinit_rsp_valid[%0d]", c), 32'(rsp_valid), 0);
            chk($sformatf("reinit_wr_addr[%0d]", c), ram_wr_address, 32'(2 * c));
            chk($sformatf("reinit_done[%0d]", c), 32'(init_done), (c == AD - 1) ? 1 : 0);
        end
        drive(mk(2'b01, 2'b00, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("post_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        drive(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("post_rsp_t1", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("post_rsp_t2", 32'(rsp_valid), 1);
        chk("post_rdata", 32'(rsp_rdata), 0);
        @(posedge clk); #1;
        chk("post_rsp_t3", 32'(rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_ram_arbiter.md
Name: byte_ram_arbiter

Overview:
- Single-clock controller that shares one byte-write simple-dual-port RAM (RAM write port + RAM read port, 1-cycle registered read) between NUM_REQ requesters.
- After reset it zero-fills the whole RAM, then grants one request per cycle round-robin and returns read data to the issuing requester.
- Sits between the NUM_REQ client interfaces and the RAM instance.
- RAM wr_clk and rd_clk are both tied to clk.

Parameters:
- ADDR_DEPTH, 32: RAM depth in words (power of two).
- DATA_WIDTH, 16: word width in bits (multiple of 8).
- ADDR_WIDTH, 32: byte-address width.
- NUM_REQ, 2: number of requesters (≥2).

Ports:
- clk  in  1  single clock, also drives RAM wr_clk/rd_clk.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  byte address; slice i = requester i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data.
- req_strb  in  NUM_REQ*DATA_WIDTH/8  byte strobes.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_rdata  out  DATA_WIDTH  read data, shared; qualified by rsp_valid.
- init_done  out  1  high once the zero-fill is complete.
- ram_wr_enable  out  1  RAM write enable.
- ram_wr_address  out  ADDR_WIDTH  RAM write byte address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_wr_strb  out  DATA_WIDTH/8  RAM byte strobes.
- ram_rd_address  out  ADDR_WIDTH  RAM read byte address.
- ram_rd_data  in  DATA_WIDTH  RAM read data, registered in RAM, valid 1 cycle after address.

Behaviour:
- Reset: clock and reset are single clk with asynchronous active-low rst_n, as fixed above. All outputs are 0 in reset: req_ready, rsp_valid, init_done, all ram_* outputs. The round-robin pointer resets to requester NUM_REQ-1, so requester 0 has first priority.
- FSM states: INIT, RUN.
  - INIT is entered on reset release.
  - The word counter idx runs 0..ADDR_DEPTH-1, one word per cycle.
  - Each INIT cycle registers: ram_wr_enable=1, ram_wr_address=idx<<$clog2(DATA_WIDTH/8), ram_wr_data=0, ram_wr_strb all ones.
  - After idx=ADDR_DEPTH-1 is issued, the FSM moves to RUN and init_done rises in that same cycle (exactly ADDR_DEPTH cycles after reset release).
  - req_ready=0 throughout INIT; incoming req_valid is ignored, not queued.
- Arbitration in RUN:
  - Combinational grant to the first valid requester after the last-granted index, wrapping modulo NUM_REQ.
  - req_ready[i] = grant[i]. The handshake completes on req_valid[i] & req_ready[i].
  - At most one request is accepted per cycle.
  - The pointer updates only on a completed handshake. A requester with valid held continuously is served within NUM_REQ accepted requests.
  - Requesters must hold valid and payload stable until ready; the bench checks this with an assertion.
- Write accepted at edge T: the ram_wr_* registers load at T, and the RAM commits at edge T+1.
  - The full address is passed through; the RAM drops the LSBs.
  - strb=0 still issues a write and changes no bytes.
  - ram_wr_enable=0 in every cycle without an accepted write.
- Read accepted at edge T:
  - ram_rd_address loads at T.
  - ram_rd_address holds its last value when idle.
  - A 1-bit-per-requester pipeline tag loads at T, and rsp_valid[i] is high for exactly the one cycle between T+1 and T+2.
  - rsp_rdata = ram_rd_data, passed through combinationally.
- Latency and throughput: read latency is 2 cycles from handshake to rsp_valid, and reads stream back-to-back at 1 per cycle. There is no response backpressure; requesters must sink rsp_valid.
- Ordering: writes and reads are issued in grant order, one per cycle. A read accepted at least 1 cycle after a write to the same word returns the new data.
- Reset mid-operation: outputs clear immediately, in-flight read tags are dropped with no rsp_valid, and the FSM restarts INIT from idx=0.

Test Plan:
- Reset release, no requests:
  - Expect ADDR_DEPTH=32 consecutive writes to byte addresses 0,2,…,62 with data 0 and strb 2'b11.
  - Expect init_done high at cycle 32.
  - Expect req_ready=0 throughout INIT, even with req_valid held high.
- Requester 0 writes addr 4, data 16'hA5C3, strb 2'b11; then reads addr 4 → rsp_valid[0] 2 cycles after read handshake with rsp_rdata=16'hA5C3, and rsp_valid[1] stays 0.
- Byte strobe: write addr 4 data 16'h1234 strb 2'b01 over 16'hA5C3, then read addr 4 → 16'hA534.
- Both requesters' valid held for 6 cycles, reads of addr 0/2:
  - Expect grants alternating 0,1,0,1,0,1.
  - Expect each rsp_valid routed to the correct requester with the correct data.
- Back-to-back reads by requester 1 on addrs 0,2,4 in 3 consecutive cycles → rsp_valid[1] high 3 consecutive cycles with data in order.
- Assert rst_n for 1 cycle while a read is in flight:
  - Expect no rsp_valid afterwards.
  - Expect INIT to restart at address 0.
  - Expect previously written addr 4 to read 0 after init_done.
